// File: rtl/afu_tree_classifier_if.sv
// Stream bundle of the tree classifier: input cachelines, per-lane issue to
// the external tree pipelines, returned results and packed output lines.
interface afu_tree_classifier_if #(
    parameter int LANES     = 8,
    parameter int KEY_W     = 16,
    parameter int IDX_IN_W  = 1,
    parameter int IDX_OUT_W = 10
);
    logic [511:0]                 in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*KEY_W-1:0]       lane_key;
    logic [LANES*IDX_IN_W-1:0]    lane_idx;
    logic                         lane_valid;
    logic [LANES*IDX_OUT_W-1:0]   res_idx;
    logic                         res_valid;
    logic [511:0]                 out_data;
    logic                         out_valid;
    logic                         out_ready;

    // Classifier side
    modport slave (
        input  in_data, in_valid, res_idx, res_valid, out_ready,
        output in_ready, lane_key, lane_idx, lane_valid, out_data, out_valid
    );

    // Host / tree side
    modport master (
        output in_data, in_valid, res_idx, res_valid, out_ready,
        input  in_ready, lane_key, lane_idx, lane_valid, out_data, out_valid
    );
endinterface

// File: rtl/afu_tree_classifier.sv
// Tree classifier datapath: unpacks cachelines into per-lane keys, issues them
// to external tree pipelines, packs GROUP result beats per output line into a
// first-word-fall-through FIFO. Credits bound the beats in flight so the FIFO
// can never overflow; start/done job control flushes a trailing partial line.
module afu_tree_classifier #(
    parameter int          LANES               = 8,
    parameter int          KEY_W               = 16,
    parameter int          IDX_IN_W            = 1,
    parameter int          IDX_OUT_W           = 10,
    parameter int          RES_W               = 16,
    parameter int          GROUP               = 2,
    parameter int          OUT_FIFO_DEPTH_BITS = 5,
    parameter logic [15:0] PAD                 = 16'h1313
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                ctx_length,
    afu_tree_classifier_if.slave       bus,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                in_count,
    output logic [31:0]                out_count
);
    localparam int D        = 2 ** OUT_FIFO_DEPTH_BITS;
    localparam int CRED_MAX = D * GROUP;
    localparam int CRED_W   = $clog2(CRED_MAX + 1);
    localparam int CS_W     = CRED_W + 1;
    localparam int FILL_W   = $clog2(GROUP + 1);
    localparam int AW       = OUT_FIFO_DEPTH_BITS;
    localparam logic [511:0] PAD_LINE = {32{PAD}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [31:0]       ctx_len;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_next;
    logic [CS_W-1:0]   cred_sum;
    logic [FILL_W-1:0] fill;
    logic [511:0]      line_buf;
    logic [511:0]      line_next;
    logic [511:0]      push_data;
    logic [8:0]        slot_base;
    logic [511:0]      fifo_mem [D];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic              accept;
    logic              pop;
    logic              push;
    logic              res_take;
    logic              line_full;
    logic              idle_start;
    logic              unused_in_bits;

    assign unused_in_bits = ^bus.in_data[511:LANES*(KEY_W+IDX_IN_W)];

    assign bus.in_ready  = (state == S_RUN) && (in_count < ctx_len) && (credits != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (fifo_cnt != '0);
    assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : '0;
    assign pop           = bus.out_valid && bus.out_ready;
    assign res_take      = bus.res_valid && (state == S_RUN);
    assign line_full     = res_take && (fill == FILL_W'(GROUP - 1));
    assign push          = line_full || ((state == S_FLUSH) && (fill != '0));
    assign push_data     = line_full ? line_next : line_buf;
    assign idle_start    = start && ((state == S_IDLE) || (state == S_DONE));
    assign busy          = (state == S_RUN) || (state == S_FLUSH) || (state == S_DRAIN);
    assign done          = (state == S_DONE);

    // Drop the returning beat's results into its slot group, zero-extended
    always_comb begin
        line_next = line_buf;
        slot_base = '0;
        for (int l = 0; l < LANES; l++) begin
            slot_base = 9'((int'(fill) * LANES + l) * RES_W);
            line_next[slot_base +: RES_W] = RES_W'(bus.res_idx[l*IDX_OUT_W +: IDX_OUT_W]);
        end
    end

    // Credit balance: one per accepted beat, GROUP back per popped line
    always_comb begin
        cred_sum = {1'b0, credits};
        if (accept)
            cred_sum = cred_sum - CS_W'(1);
        if (pop)
            cred_sum = cred_sum + CS_W'(GROUP);
        credits_next = (cred_sum > CS_W'(CRED_MAX)) ? CRED_W'(CRED_MAX) : cred_sum[CRED_W-1:0];
    end

    // Job FSM, counters, credits, packer fill level and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ctx_len   <= '0;
            credits   <= '0;
            fill      <= '0;
            in_count  <= '0;
            out_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            credits <= credits_next;
            if (accept)
                in_count <= in_count + 32'd1;
            if (res_take) begin
                out_count <= out_count + 32'd1;
                fill      <= line_full ? '0 : fill + FILL_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ctx_len   <= ctx_length;
                        in_count  <= '0;
                        out_count <= '0;
                        credits   <= CRED_W'(CRED_MAX);
                        fill      <= '0;
                        state     <= (ctx_length == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_count == ctx_len)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    fill  <= '0;
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_cnt == '0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue stage: register accepted keys/indices, strobe the trees one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.lane_valid <= 1'b0;
            bus.lane_key   <= '0;
            bus.lane_idx   <= '0;
        end else begin
            bus.lane_valid <= accept;
            if (accept) begin
                bus.lane_key <= bus.in_data[LANES*KEY_W-1:0];
                bus.lane_idx <= bus.in_data[LANES*KEY_W +: LANES*IDX_IN_W];
            end
        end
    end

    // Line assembly buffer: re-armed with PAD at job start and after every push
    always_ff @(posedge clk) begin
        if (idle_start || push)
            line_buf <= PAD_LINE;
        else if (res_take)
            line_buf <= line_next;
    end

    // FIFO storage; occupancy is tracked with the control state above
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_afu_tree_classifier.sv
// Directed bench for afu_tree_classifier: tree pipelines modelled as a
// configurable delay returning key[9:0], with a beat source and line sink.
module tb_afu_tree_classifier;
    localparam int LANES = 8;
    localparam int KEY_W = 16;
    localparam int IDX_IN_W = 1;
    localparam int IDX_OUT_W = 10;
    localparam int RES_W = 16;
    localparam int GROUP = 2;
    localparam int DB = 5;
    localparam int D = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ctx_length = '0;
    logic        busy, done;
    logic [31:0] in_count, out_count;

    afu_tree_classifier_if #(.LANES(LANES), .KEY_W(KEY_W), .IDX_IN_W(IDX_IN_W),
                             .IDX_OUT_W(IDX_OUT_W)) bus ();

    afu_tree_classifier #(.LANES(LANES), .KEY_W(KEY_W), .IDX_IN_W(IDX_IN_W),
                          .IDX_OUT_W(IDX_OUT_W), .RES_W(RES_W), .GROUP(GROUP),
                          .OUT_FIFO_DEPTH_BITS(DB), .PAD(16'h1313)) dut (
        .clk(clk), .rst(rst), .start(start), .ctx_length(ctx_length), .bus(bus),
        .busy(busy), .done(done), .in_count(in_count), .out_count(out_count));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tree model: delay of lat cycles, result = key[9:0] per lane
    bit [LANES*IDX_OUT_W-1:0] pipe_d [16];
    bit                       pipe_v [16];
    int                       lat = 10;
    always @(posedge clk) begin
        pipe_v[0] <= bus.lane_valid;
        for (int l = 0; l < LANES; l++)
            pipe_d[0][l*IDX_OUT_W +: IDX_OUT_W] <= bus.lane_key[l*KEY_W +: IDX_OUT_W];
        for (int i = 1; i < 16; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign bus.res_valid = pipe_v[lat-1];
    assign bus.res_idx   = pipe_d[lat-1];

    int checks = 0;
    int errors = 0;
    int src_idx = 0, src_num = 0, rdy_cnt = 0, resv_cnt = 0, ovf_cnt = 0, done_cyc = 0;
    bit src_en = 0;
    logic [15:0] key_ofs = '0;
    logic [511:0] got [$];
    logic [127:0] lkey [$];
    logic [7:0]   lidx [$];
    int pop_cyc [$], take_cyc [$], lv_cyc [$];

    function automatic logic [15:0] key_of(int b, int l);
        return key_ofs + 16'(b * LANES + l + 1);
    endfunction

    function automatic logic [127:0] beat_keys(int b);
        logic [127:0] r;
        for (int l = 0; l < LANES; l++) r[l*16 +: 16] = key_of(b, l);
        return r;
    endfunction

    function automatic logic [7:0] beat_idx(int b);
        logic [7:0] r;
        for (int l = 0; l < LANES; l++) r[l] = ((b + l) % 2) == 1;
        return r;
    endfunction

    function automatic logic [511:0] make_beat(int b);
        logic [511:0] r;
        r = {16{32'hA5A5_5A5A}};
        r[127:0]   = beat_keys(b);
        r[135:128] = beat_idx(b);
        return r;
    endfunction

    function automatic logic [511:0] exp_line(int n, int total);
        logic [511:0] r;
        logic [15:0]  k;
        r = {32{16'h1313}};
        for (int g = 0; g < GROUP; g++)
            for (int l = 0; l < LANES; l++)
                if (n * GROUP + g < total) begin
                    k = key_of(n * GROUP + g, l);
                    r[(g*LANES+l)*RES_W +: RES_W] = {6'b0, k[9:0]};
                end
        return r;
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic source_loop();
        bit take;
        forever begin
            @(negedge clk);
            take = bus.in_valid && bus.in_ready;
            if (take) take_cyc.push_back(cyc);
            @(posedge clk);
            #2;
            if (take) src_idx++;
            bus.in_valid = src_en && (src_idx < src_num);
            bus.in_data  = make_beat(src_idx);
        end
    endtask

    task automatic sink_loop();
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                pop_cyc.push_back(cyc);
            end
            if (bus.lane_valid) begin
                lkey.push_back(bus.lane_key);
                lidx.push_back(bus.lane_idx);
                lv_cyc.push_back(cyc);
            end
            if (bus.in_ready) rdy_cnt++;
            if (bus.res_valid) resv_cnt++;
            if (dut.fifo_cnt > D) ovf_cnt++;
        end
    endtask

    task automatic wait_done(int limit, string tag);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        chk(tag, done, 1'b1);
    endtask

    task automatic run_job(int len, logic [15:0] ofs);
        got.delete(); pop_cyc.delete(); take_cyc.delete();
        lkey.delete(); lidx.delete(); lv_cyc.delete();
        rdy_cnt = 0;
        key_ofs = ofs;
        src_idx = 0;
        src_num = len + 3;
        src_en  = 1;
        ctx_length = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        fork
            source_loop();
            sink_loop();
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lane_valid", bus.lane_valid, 1'b0);
        chk("rst_lane_key", bus.lane_key, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_in_count", in_count, '0);
        chk("rst_out_count", out_count, '0);
        rst = 1'b0;
        tick();

        // Zero-length job from IDLE
        bus.out_ready = 1'b1;
        chk("zero_done_before", done, 1'b0);
        run_job(0, 16'h0000);
        chk("zero_done_next", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        repeat (5) tick();
        chk("zero_lines", got.size(), 0);
        chk("zero_in_ready", rdy_cnt, 0);
        chk("zero_src", src_idx, 0);

        // Four beats, two full lines
        lat = 10;
        run_job(4, 16'h0000);
        chk("t1_busy", busy, 1'b1);
        chk("t1_done_clear", done, 1'b0);
        wait_done(300, "t1_done");
        chk("t1_lines", got.size(), 2);
        chk("t1_l0_s0", got[0][15:0], 16'h0001);
        chk("t1_l0_s15", got[0][255:240], 16'h0010);
        chk("t1_l0_pad", got[0][511:256], {16{16'h1313}});
        chk("t1_l1_s0", got[1][15:0], 16'h0011);
        chk("t1_l1_s15", got[1][255:240], 16'h0020);
        chk("t1_line0", got[0], exp_line(0, 4));
        chk("t1_line1", got[1], exp_line(1, 4));
        chk("t1_in_count", in_count, 4);
        chk("t1_out_count", out_count, 4);
        chk("t1_src_stop", src_idx, 4);
        chk("t1_lane_key0", lkey[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t1_lane_idx1", lidx[1], 8'h55);
        chk("t1_lane_key3", lkey[3], beat_keys(3));
        chk("t1_issue_lat", lv_cyc[0] - take_cyc[0], 1);

        // Three beats: second line partial, flushed with PAD
        run_job(3, 16'h0A50);
        wait_done(300, "t2_done");
        chk("t2_lines", got.size(), 2);
        chk("t2_l1_s0", got[1][15:0], 16'h0261);
        chk("t2_l1_pad", got[1][511:128], {24{16'h1313}});
        chk("t2_line0", got[0], exp_line(0, 3));
        chk("t2_line1", got[1], exp_line(1, 3));
        chk("t2_done_after_pop", done_cyc > pop_cyc[pop_cyc.size()-1], 1'b1);
        chk("t2_in_count", in_count, 3);

        // Backpressure: credits stop input at D*GROUP beats
        bus.out_ready = 1'b0;
        run_job(100, 16'h1000);
        n = 0;
        while (in_count < 64 && n < 400) begin
            tick();
            n++;
        end
        repeat (20) tick();
        chk("t3_in_stall", in_count, 64);
        chk("t3_in_ready", bus.in_ready, 1'b0);
        chk("t3_out_valid", bus.out_valid, 1'b1);
        chk("t3_out_count", out_count, 64);
        bus.out_ready = 1'b1;
        wait_done(3000, "t3_done");
        chk("t3_lines", got.size(), 50);
        for (int i = 0; i < got.size() && i < 50; i++)
            chk($sformatf("t3_line%0d", i), got[i], exp_line(i, 100));
        chk("t3_in_count", in_count, 100);
        chk("t3_src_stop", src_idx, 100);

        // Reset mid-job with results in flight
        run_job(8, 16'h2000);
        n = 0;
        while (in_count < 5 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        src_en = 0;
        tick();
        chk("t5_busy", busy, 1'b0);
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_in_ready", bus.in_ready, 1'b0);
        chk("t5_in_count", in_count, 0);
        rst = 1'b0;
        resv_cnt = 0;
        repeat (15) tick();
        chk("t5_straggle_seen", resv_cnt != 0, 1'b1);
        chk("t5_out_count", out_count, 0);
        chk("t5_out_valid_idle", bus.out_valid, 1'b0);
        chk("t5_done_idle", done, 1'b0);
        run_job(2, 16'h3000);
        wait_done(300, "t5_done");
        chk("t5_lines", got.size(), 1);
        chk("t5_line0", got[0], exp_line(0, 2));
        chk("t5_out_count2", out_count, 2);

        // Full throughput with single-cycle trees
        lat = 1;
        run_job(20, 16'hFC00);
        wait_done(300, "t6_done");
        chk("t6_takes", take_cyc.size(), 20);
        chk("t6_take_span", take_cyc[take_cyc.size()-1] - take_cyc[0], 19);
        chk("t6_ready_cycles", rdy_cnt, 20);
        chk("t6_lines", got.size(), 10);
        for (int i = 0; i + 1 < pop_cyc.size(); i++)
            chk($sformatf("t6_gap%0d", i), pop_cyc[i+1] - pop_cyc[i], GROUP);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("t6_line%0d", i), got[i], exp_line(i, 20));

        chk("fifo_never_over_D", ovf_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
